pid_multi_core: RTL and testbench
=================================

PID_MULTI_CORE -- requirements
Module: pid_multi_core

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of time-multiplexed control channels (1-8).
REQ-002 SHALL have parameter ADC_BITWIDTH, default 8: unsigned width of the setpoint and measurement.
REQ-003 SHALL have parameter REG_BITWIDTH, default 16: signed coefficient width.
REQ-004 SHALL have parameter FRAC_BITWIDTH, default 8: fractional bits of the coefficients and of the internal output history.
REQ-005 SHALL have port clk_i  in  1  single clock; all logic SHALL be on its rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port start_i  in  1  request one update pass over all channels.
REQ-008 SHALL have port chan_en_i  in  CHANNELS  per-channel enable.
REQ-009 SHALL have port adc_value_i  in  CHANNELS*ADC_BITWIDTH  measurements; channel c occupies slice c.
REQ-010 SHALL have port set_value_i  in  CHANNELS*ADC_BITWIDTH  setpoints, sliced the same way.
REQ-011 SHALL have ports b0_i, b1_i, b2_i, a1_i, a2_i  in  REG_BITWIDTH each  signed Q(FRAC_BITWIDTH) coefficients, shared by all channels.
REQ-012 SHALL have ports out_min_i, out_max_i  in  ADC_BITWIDTH+1 each  signed output clamp limits; out_min_i <= out_max_i is required of the driver.
REQ-013 SHALL have port out_val_o  out  CHANNELS*(ADC_BITWIDTH+1)  signed controller outputs.
REQ-014 SHALL have port sat_o  out  CHANNELS  set while the channel's last result was clamped.
REQ-015 SHALL have port busy_o  out  1  pass in progress.
REQ-016 SHALL have port done_o  out  1  one-cycle pulse when a pass completes.

Function
REQ-017 SHALL compute per channel y[k] = b0*e[k] + b1*e[k-1] + b2*e[k-2] - a1*y[k-1] - a2*y[k-2], with e = set - adc as a signed (ADC_BITWIDTH+1)-bit integer.
REQ-018 SHALL hold e[k-1], e[k-2], y[k-1] and y[k-2] separately per channel; y history SHALL be signed with FRAC_BITWIDTH fractional bits.
REQ-019 SHALL form coeff*e products exactly, SHALL form coeff*y products with an arithmetic right shift by FRAC_BITWIDTH, and SHALL accumulate in an accumulator wide enough that no intermediate overflow occurs (at least REG_BITWIDTH+ADC_BITWIDTH+FRAC_BITWIDTH+4 bits).
REQ-020 SHALL use a state machine with states IDLE, LOAD, MAC, WB, SKIP and DONE, and a channel index that counts 0 to CHANNELS-1.
REQ-021 SHALL accept start_i only in IDLE or DONE; start_i while busy_o=1 SHALL be ignored and not queued.
REQ-022 On acceptance, the next state SHALL be LOAD for channel 0 if it is enabled, otherwise SKIP; busy_o SHALL be 1 in every state except IDLE and DONE.
REQ-023 LOAD SHALL sample that channel's adc/set slices and clear the accumulator, taking 1 cycle.
REQ-024 MAC SHALL perform exactly 5 multiply-accumulates, one per cycle (5 cycles).
REQ-025 WB SHALL take 1 cycle and SHALL:
  - clamp acc to [out_min_i, out_max_i] * 2^FRAC_BITWIDTH;
  - write the clamped value as y[k] (anti-windup: history never exceeds the limits);
  - shift the e and y histories;
  - register out_val_o = clamped >>> FRAC_BITWIDTH;
  - set sat_o[c] = 1 if clamping occurred, else 0.
REQ-026 An enabled channel SHALL take 7 cycles; a disabled channel SHALL take 1 SKIP cycle that zeroes its histories, out_val_o slice and sat_o bit.
REQ-027 After the last channel, the block SHALL enter DONE for 1 cycle with done_o=1, then go to IDLE, or to LOAD/SKIP of channel 0 if start_i=1 in DONE.
REQ-028 Total latency SHALL be: start accepted at edge t gives done_o high in cycle t + 1 + 7*E + D, where E = enabled channels and D = disabled channels.
REQ-029 Coefficient, limit and chan_en_i changes during a pass SHALL take effect at the next cycle that uses them; chan_en_i SHALL be evaluated at each channel's entry.

Reset
REQ-030 rst_i=1 SHALL, at the next edge and regardless of state (including mid-MAC), force: state IDLE, channel index 0, accumulator 0, all histories 0, out_val_o 0, sat_o 0, busy_o 0, done_o 0.
REQ-031 A pass interrupted by reset SHALL NOT produce done_o and SHALL NOT be resumed.

Verification (CHANNELS=2, ADC=8, REG=16, FRAC=8; limits -255/255 unless stated)
REQ-032 P-only: b0=256, others 0, ch0 set=100 adc=60, ch1 set=10 adc=50, start at cycle 0 -> done_o in cycle 15 only; out ch0=40, ch1=-40; sat_o=00.
REQ-033 Integrator with anti-windup: b0=256, a1=-256, out_max=25, e=10 constant -> outputs 10, 20, 25 (sat=1), 25; then e=-10 -> 15 on the next pass (sat=0).
REQ-034 Negative clamp: set=0, adc=200, b0=256, out_min=-100 -> out=-100, sat=1.
REQ-035 Disabled channel: chan_en_i=01, start at cycle 0 -> done_o in cycle 9; ch1 out=0, sat=0; start_i pulsed in cycle 4 is ignored.
REQ-036 Reset mid-pass: rst_i in the 3rd MAC cycle -> next cycle busy_o=0, all outputs 0, no done_o; a following pass matches REQ-032 exactly.

Source files
------------

// File: rtl/pid_multi_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pid_multi_core: time-multiplexed multi-channel IIR/PID with clamped output |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pid_multi_core #(
  parameter int CHANNELS      = 2,
  parameter int ADC_BITWIDTH  = 8,
  parameter int REG_BITWIDTH  = 16,
  parameter int FRAC_BITWIDTH = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   start_i,
  input  logic [CHANNELS-1:0]                    chan_en_i,
  input  logic [CHANNELS*ADC_BITWIDTH-1:0]       adc_value_i,
  input  logic [CHANNELS*ADC_BITWIDTH-1:0]       set_value_i,
  input  logic signed [REG_BITWIDTH-1:0]         b0_i,
  input  logic signed [REG_BITWIDTH-1:0]         b1_i,
  input  logic signed [REG_BITWIDTH-1:0]         b2_i,
  input  logic signed [REG_BITWIDTH-1:0]         a1_i,
  input  logic signed [REG_BITWIDTH-1:0]         a2_i,
  input  logic signed [ADC_BITWIDTH:0]           out_min_i,
  input  logic signed [ADC_BITWIDTH:0]           out_max_i,
  output logic [CHANNELS*(ADC_BITWIDTH+1)-1:0]   out_val_o,
  output logic [CHANNELS-1:0]                    sat_o,
  output logic                                   busy_o,
  output logic                                   done_o
);
  localparam int EW   = ADC_BITWIDTH + 1;
  localparam int YW   = EW + FRAC_BITWIDTH;
  localparam int ACCW = REG_BITWIDTH + ADC_BITWIDTH + FRAC_BITWIDTH + 4;
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_SKIP = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [CW-1:0]           ch_q, ch_d, ch_nxt;
  logic [2:0]              mac_q, mac_d;
  logic signed [ACCW-1:0]  acc_q;
  logic signed [EW-1:0]    e_q;
  logic signed [EW-1:0]    e1_q [CHANNELS];
  logic signed [EW-1:0]    e2_q [CHANNELS];
  logic signed [YW-1:0]    y1_q [CHANNELS];
  logic signed [YW-1:0]    y2_q [CHANNELS];
  logic signed [EW-1:0]    out_q [CHANNELS];
  logic [CHANNELS-1:0]     sat_q;

  logic signed [REG_BITWIDTH-1:0] coef;
  logic signed [ACCW-1:0]  opnd, prod, term;
  logic                    y_term;
  logic signed [YW-1:0]    hi_y, lo_y, y_new;
  logic                    over, under;

  assign ch_nxt = ch_q + CW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      mac_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mac_q   <= mac_d;
    end
  end

  // Enable is looked up as each channel is entered, so mid-pass changes apply.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    mac_d   = mac_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_i) begin
          ch_d    = '0;
          state_d = chan_en_i[0] ? S_LOAD : S_SKIP;
        end
      end
      S_LOAD: begin
        state_d = S_MAC;
        mac_d   = '0;
      end
      S_MAC: begin
        if (mac_q == 3'd4) state_d = S_WB;
        else               mac_d   = mac_q + 3'd1;
      end
      S_WB, S_SKIP: begin
        if (ch_q == CW'(CHANNELS - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_nxt;
          state_d = chan_en_i[ch_nxt] ? S_LOAD : S_SKIP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != S_IDLE) && (state_q != S_DONE);
    done_o = (state_q == S_DONE);
  end

  always_comb begin
    coef   = b0_i;
    opnd   = ACCW'(e_q);
    y_term = 1'b0;
    case (mac_q)
      3'd1: begin coef = b1_i; opnd = ACCW'(e1_q[ch_q]); end
      3'd2: begin coef = b2_i; opnd = ACCW'(e2_q[ch_q]); end
      3'd3: begin coef = a1_i; opnd = ACCW'(y1_q[ch_q]); y_term = 1'b1; end
      3'd4: begin coef = a2_i; opnd = ACCW'(y2_q[ch_q]); y_term = 1'b1; end
      default: ;
    endcase
  end

  // Feedback products are rescaled back to Q(FRAC) before subtraction.
  assign prod = ACCW'(coef) * opnd;
  assign term = y_term ? -(prod >>> FRAC_BITWIDTH) : prod;

  assign hi_y  = {out_max_i, {FRAC_BITWIDTH{1'b0}}};
  assign lo_y  = {out_min_i, {FRAC_BITWIDTH{1'b0}}};
  assign over  = acc_q > ACCW'(hi_y);
  assign under = acc_q < ACCW'(lo_y);
  assign y_new = over ? hi_y : (under ? lo_y : acc_q[YW-1:0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      e_q   <= '0;
      sat_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        e1_q[c]  <= '0;
        e2_q[c]  <= '0;
        y1_q[c]  <= '0;
        y2_q[c]  <= '0;
        out_q[c] <= '0;
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          acc_q <= '0;
          e_q   <= $signed({1'b0, set_value_i[ch_q*ADC_BITWIDTH +: ADC_BITWIDTH]})
                 - $signed({1'b0, adc_value_i[ch_q*ADC_BITWIDTH +: ADC_BITWIDTH]});
        end
        S_MAC: acc_q <= acc_q + term;
        S_WB: begin
          e2_q[ch_q]  <= e1_q[ch_q];
          e1_q[ch_q]  <= e_q;
          y2_q[ch_q]  <= y1_q[ch_q];
          y1_q[ch_q]  <= y_new;
          out_q[ch_q] <= y_new[YW-1 -: EW];
          sat_q[ch_q] <= over | under;
        end
        S_SKIP: begin
          e1_q[ch_q]  <= '0;
          e2_q[ch_q]  <= '0;
          y1_q[ch_q]  <= '0;
          y2_q[ch_q]  <= '0;
          out_q[ch_q] <= '0;
          sat_q[ch_q] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign out_val_o[g*EW +: EW] = out_q[g];
  end
  assign sat_o = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_pid_multi_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pid_multi_core: scoreboard bench with a behavioural controller model   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pid_multi_core;
  localparam int CH = 2;
  localparam int AW = 8;
  localparam int RW = 16;
  localparam int FW = 8;
  localparam int EW = AW + 1;

  logic                   clk = 1'b0;
  logic                   rst_i, start_i;
  logic [CH-1:0]          chan_en_i;
  logic [CH*AW-1:0]       adc_value_i, set_value_i;
  logic signed [RW-1:0]   b0_i, b1_i, b2_i, a1_i, a2_i;
  logic signed [EW-1:0]   out_min_i, out_max_i;
  logic [CH*EW-1:0]       out_val_o;
  logic [CH-1:0]          sat_o;
  logic                   busy_o, done_o;

  pid_multi_core #(.CHANNELS(CH), .ADC_BITWIDTH(AW), .REG_BITWIDTH(RW), .FRAC_BITWIDTH(FW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .chan_en_i(chan_en_i),
    .adc_value_i(adc_value_i), .set_value_i(set_value_i),
    .b0_i(b0_i), .b1_i(b1_i), .b2_i(b2_i), .a1_i(a1_i), .a2_i(a2_i),
    .out_min_i(out_min_i), .out_max_i(out_max_i),
    .out_val_o(out_val_o), .sat_o(sat_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, n_done = 0;

  int set_v [CH];
  int adc_v [CH];
  logic [CH-1:0] en_v;
  int cb0, cb1, cb2, ca1, ca2, lo, hi;
  longint m_e1 [CH], m_e2 [CH], m_y1 [CH], m_y2 [CH];

  logic [CH*EW-1:0] q_out [$];
  logic [CH-1:0]    q_sat [$];
  int               q_cyc [$];

  task automatic chk(input string nm, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic chk_out(input string nm, input int c, input int exp_v);
    chk(nm, $signed(out_val_o[c*EW +: EW]), exp_v);
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_e1[c] = 0; m_e2[c] = 0; m_y1[c] = 0; m_y2[c] = 0;
    end
  endtask

  // Difference equation in plain integer arithmetic; y kept in units of 1/2^FW.
  task automatic model_pass(input int s);
    logic [CH*EW-1:0] ov;
    logic [CH-1:0]    sv;
    int ne;
    longint e, acc, top, bot, yv;
    ov = '0; sv = '0; ne = 0;
    for (int c = 0; c < CH; c++) begin
      if (en_v[c]) begin
        e   = set_v[c] - adc_v[c];
        acc = cb0 * e + cb1 * m_e1[c] + cb2 * m_e2[c]
            - ((ca1 * m_y1[c]) >>> FW) - ((ca2 * m_y2[c]) >>> FW);
        top = longint'(hi) * (longint'(1) << FW);
        bot = longint'(lo) * (longint'(1) << FW);
        yv  = acc;
        if (acc > top) begin yv = top; sv[c] = 1'b1; end
        else if (acc < bot) begin yv = bot; sv[c] = 1'b1; end
        m_e2[c] = m_e1[c]; m_e1[c] = e;
        m_y2[c] = m_y1[c]; m_y1[c] = yv;
        ov[c*EW +: EW] = EW'(yv >>> FW);
        ne++;
      end else begin
        m_e1[c] = 0; m_e2[c] = 0; m_y1[c] = 0; m_y2[c] = 0;
      end
    end
    q_out.push_back(ov);
    q_sat.push_back(sv);
    q_cyc.push_back(s + 1 + 7 * ne + (CH - ne));
  endtask

  task automatic apply();
    for (int c = 0; c < CH; c++) begin
      set_value_i[c*AW +: AW] = AW'(set_v[c]);
      adc_value_i[c*AW +: AW] = AW'(adc_v[c]);
    end
    chan_en_i = en_v;
    b0_i = RW'(cb0); b1_i = RW'(cb1); b2_i = RW'(cb2);
    a1_i = RW'(ca1); a2_i = RW'(ca2);
    out_min_i = EW'(lo); out_max_i = EW'(hi);
  endtask

  task automatic issue_start();
    @(negedge clk);
    apply();
    start_i = 1'b1;
    model_pass(cyc);
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
  endtask

  task automatic wait_done();
    int base, k;
    base = n_done; k = 0;
    while (n_done == base && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("pass_done_seen", (n_done != base) ? 1 : 0, 1);
  endtask

  // Re-issues start during the DONE cycle of the pass in flight.
  task automatic start_at_done();
    int k;
    k = 0;
    @(negedge clk);
    while (!done_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("done_for_chain", done_o, 1);
    start_i = 1'b1;
    model_pass(cyc);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  logic [CH*EW-1:0] mo;
  logic [CH-1:0]    ms;
  int               mc;

  always @(negedge clk) begin
    if (done_o) begin
      n_done++;
      if (q_cyc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual=done_o high at cycle %0d expected=no pass pending", cyc);
      end else begin
        mo = q_out.pop_front();
        ms = q_sat.pop_front();
        mc = q_cyc.pop_front();
        chk("done_cycle", cyc, mc);
        for (int c = 0; c < CH; c++)
          chk($sformatf("out_ch%0d", c), $signed(out_val_o[c*EW +: EW]), $signed(mo[c*EW +: EW]));
        chk("sat", sat_o, ms);
        chk("busy_at_done", busy_o, 0);
      end
    end
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0;
    en_v = '1; cb0 = 0; cb1 = 0; cb2 = 0; ca1 = 0; ca2 = 0; lo = -255; hi = 255;
    for (int c = 0; c < CH; c++) begin set_v[c] = 0; adc_v[c] = 0; end
    apply();
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_out", out_val_o, 0);
    chk("rst_sat", sat_o, 0);
    rst_i = 1'b0;

    // Proportional only
    cb0 = 256;
    set_v[0] = 100; adc_v[0] = 60; set_v[1] = 10; adc_v[1] = 50;
    issue_start(); wait_done();
    chk_out("p_ch0", 0, 40); chk_out("p_ch1", 1, -40); chk("p_sat", sat_o, 0);

    // Clear histories with an all-disabled pass
    en_v = '0;
    issue_start(); wait_done();
    chk("skip_out", out_val_o, 0);

    // Integrator with anti-windup, passes 2 and 3 chained through DONE
    en_v = '1; ca1 = -256; hi = 25;
    set_v[0] = 60; adc_v[0] = 50; set_v[1] = 30; adc_v[1] = 20;
    issue_start(); wait_done();
    chk_out("int1", 0, 10); chk("int1_sat", sat_o, 0);
    issue_start();
    start_at_done();
    wait_done();
    chk_out("int3", 0, 25); chk("int3_sat", sat_o, 2'b11);
    issue_start(); wait_done();
    chk_out("int4", 0, 25);
    set_v[0] = 40; adc_v[0] = 50; set_v[1] = 10; adc_v[1] = 20;
    issue_start(); wait_done();
    chk_out("int5", 0, 15); chk("int5_sat", sat_o, 0);

    // Negative clamp
    ca1 = 0; hi = 255; lo = -100;
    set_v[0] = 0; adc_v[0] = 200; set_v[1] = 50; adc_v[1] = 20;
    issue_start(); wait_done();
    chk_out("neg_ch0", 0, -100); chk("neg_sat0", sat_o[0], 1); chk_out("neg_ch1", 1, 30);

    // Disabled channel with an ignored start while busy
    lo = -255; en_v = 2'b01;
    set_v[0] = 100; adc_v[0] = 60;
    issue_start();
    repeat (3) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    chk_out("dis_ch1", 1, 0); chk("dis_sat1", sat_o[1], 0); chk_out("dis_ch0", 0, 40);
    repeat (25) @(negedge clk);

    // Reset during the third MAC cycle
    en_v = '1;
    set_v[0] = 100; adc_v[0] = 60; set_v[1] = 10; adc_v[1] = 50;
    issue_start();
    repeat (3) @(negedge clk);
    chk("busy_mid_mac", busy_o, 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("mrst_busy", busy_o, 0); chk("mrst_done", done_o, 0);
    chk("mrst_out", out_val_o, 0); chk("mrst_sat", sat_o, 0);
    q_out.delete(); q_sat.delete(); q_cyc.delete();
    model_reset();
    repeat (25) @(negedge clk);
    issue_start(); wait_done();
    chk_out("post_rst_ch0", 0, 40); chk_out("post_rst_ch1", 1, -40); chk("post_rst_sat", sat_o, 0);

    // Randomized passes against the model
    for (int i = 0; i < 14; i++) begin
      cb0 = int'($urandom_range(0, 1023)) - 512;
      cb1 = int'($urandom_range(0, 1023)) - 512;
      cb2 = int'($urandom_range(0, 511)) - 256;
      ca1 = int'($urandom_range(0, 511)) - 256;
      ca2 = int'($urandom_range(0, 255)) - 128;
      lo  = -int'($urandom_range(0, 256));
      hi  = int'($urandom_range(0, 255));
      en_v = CH'($urandom_range(0, (1 << CH) - 1));
      for (int c = 0; c < CH; c++) begin
        set_v[c] = int'($urandom_range(0, 255));
        adc_v[c] = int'($urandom_range(0, 255));
      end
      issue_start(); wait_done();
    end

    repeat (30) @(negedge clk);
    chk("scoreboard_drained", q_cyc.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
